// File: rtl/vxe_vpu_cmd_disp_pkg.sv
// vxe_vpu_cmd_disp_pkg: opcodes, field widths and FSM encoding shared by the VPU command dispatcher
package vxe_vpu_cmd_disp_pkg;
  localparam int OP_W = 5;
  localparam int TH_W = 3;
  localparam int PL_W = 48;
  localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OP_SYNC = 5'h01;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_SYNC     = 2'd3
  } state_t;
endpackage

// File: rtl/vxe_vpu_cmd_disp.sv
// vxe_vpu_cmd_disp: pops VPU queue commands and dispatches them one at a time to per-thread engines
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   i_clear              abort in-flight command and clear the sticky error
//   o_busy, o_err        dispatcher/thread activity, sticky bad-thread error
//   i_vld, o_rd          queue head valid, queue pop
//   i_op, i_th, i_pl     queue head opcode, thread index, payload
//   o_thr_vld, i_thr_ack one-hot per-thread command valid and its accept
//   o_thr_op, o_thr_pl   command broadcast to every thread
//   i_thr_busy           per-thread execution activity
module vxe_vpu_cmd_disp
  import vxe_vpu_cmd_disp_pkg::*;
#(
  parameter int NTHR = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_clear,
  output logic            o_busy,
  output logic            o_err,
  input  logic            i_vld,
  output logic            o_rd,
  input  logic [OP_W-1:0] i_op,
  input  logic [TH_W-1:0] i_th,
  input  logic [PL_W-1:0] i_pl,
  output logic [NTHR-1:0] o_thr_vld,
  input  logic [NTHR-1:0] i_thr_ack,
  output logic [OP_W-1:0] o_thr_op,
  output logic [PL_W-1:0] o_thr_pl,
  input  logic [NTHR-1:0] i_thr_busy
);
  localparam logic [TH_W:0] NTHR_L = (TH_W+1)'(NTHR);
  state_t          state;
  logic [OP_W-1:0] cmd_op;
  logic [TH_W-1:0] cmd_th;
  logic [PL_W-1:0] cmd_pl;
  logic [NTHR-1:0] th_sel;
  logic            th_ok;
  logic            ack_hit;
  genvar t;
  generate
    for (t = 0; t < NTHR; t++) begin : g_sel
      assign th_sel[t] = cmd_th == TH_W'(t);
    end
  endgenerate
  assign th_ok   = {1'b0, cmd_th} < NTHR_L;
  // only the ack of the thread currently addressed completes a dispatch
  assign ack_hit = |(i_thr_ack & o_thr_vld);
  assign o_rd    = (state == ST_IDLE) & i_vld & ~i_clear;
  assign o_busy  = (state != ST_IDLE) | (|i_thr_busy);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      cmd_op    <= '0;
      cmd_th    <= '0;
      cmd_pl    <= '0;
      o_thr_vld <= '0;
      o_thr_op  <= '0;
      o_thr_pl  <= '0;
      o_err     <= 1'b0;
    end else if (i_clear) begin
      state     <= ST_IDLE;
      o_thr_vld <= '0;
      o_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_vld) begin
          cmd_op <= i_op;
          cmd_th <= i_th;
          cmd_pl <= i_pl;
          state  <= ST_DECODE;
        end
        ST_DECODE: begin
          if (cmd_op == OP_NOP) state <= ST_IDLE;
          else if (cmd_op == OP_SYNC) state <= ST_SYNC;
          else if (!th_ok) begin
            o_err <= 1'b1;
            state <= ST_IDLE;
          end else begin
            o_thr_vld <= th_sel;
            o_thr_op  <= cmd_op;
            o_thr_pl  <= cmd_pl;
            state     <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: if (ack_hit) begin
          o_thr_vld <= '0;
          state     <= ST_IDLE;
        end
        ST_SYNC: if (!(|i_thr_busy)) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vxe_vpu_cmd_disp.sv
// tb_vxe_vpu_cmd_disp: scoreboard bench for the VPU command dispatcher with a timing-rule reference model
module tb_vxe_vpu_cmd_disp;
  localparam int NTHR = 6;
  localparam int INF  = 1 << 30;
  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  th;
    logic [47:0] pl;
  } cmd_t;
  typedef struct {
    cmd_t c;
    int   pcyc;
  } exp_t;
  logic clk = 0, nrst = 0, i_clear = 0, i_vld = 0;
  logic o_busy, o_err, o_rd;
  logic [4:0] i_op = '0;
  logic [2:0] i_th = '0;
  logic [47:0] i_pl = '0;
  logic [NTHR-1:0] o_thr_vld, i_thr_ack = '0, i_thr_busy = '0;
  logic [4:0] o_thr_op;
  logic [47:0] o_thr_pl;
  cmd_t cq[$];
  exp_t sb[$];
  int pop_log[$];
  int total = 0, bad = 0, cyc = 0;
  int ready_at = 0, last_pop = -1, err_at = INF, fl_th = 0, fl_disp = 0, sync_from = 0;
  bit fl_on = 0, sync_on = 0;
  int ack_mode = 2;
  logic [NTHR-1:0] ack_force = '0, busy_knob = '0, ack_v, prev_vld = '0;
  bit clear_req = 0, rnd = 0;
  cmd_t pc, cur;
  exp_t me;

  vxe_vpu_cmd_disp #(.NTHR(NTHR)) dut (
    .clk(clk), .nrst(nrst), .i_clear(i_clear), .o_busy(o_busy), .o_err(o_err),
    .i_vld(i_vld), .o_rd(o_rd), .i_op(i_op), .i_th(i_th), .i_pl(i_pl),
    .o_thr_vld(o_thr_vld), .i_thr_ack(i_thr_ack), .o_thr_op(o_thr_op),
    .o_thr_pl(o_thr_pl), .i_thr_busy(i_thr_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    int t = 0;
    while (cyc < c && t < 1000) begin
      tick();
      t++;
    end
  endtask

  task automatic wait_pops(int n);
    int t = 0;
    while (pop_log.size() < n && t < 500) begin
      tick();
      t++;
    end
    chk("pop wait", 64'(pop_log.size() >= n), 1);
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  // queue, thread responder and cycle-level timing model
  always @(negedge clk) begin
    if (!nrst) begin
      i_vld = 0;
      i_clear = 0;
      i_thr_ack = '0;
      i_thr_busy = '0;
    end else begin
      i_clear = clear_req || (rnd && $urandom_range(59) == 0);
      clear_req = 0;
      i_thr_busy = rnd ? (($urandom_range(3) == 0) ? NTHR'($urandom) : '0) : busy_knob;
      i_vld = cq.size() > 0;
      if (i_vld) {i_op, i_th, i_pl} = cq[0];
      ack_v = ack_force;
      if (o_thr_vld != '0 && ack_mode == 0 && $urandom_range(2) == 0) ack_v |= o_thr_vld;
      if (o_thr_vld != '0 && ack_mode == 1) ack_v |= o_thr_vld;
      if (rnd) ack_v |= NTHR'($urandom) & ~o_thr_vld;
      i_thr_ack = ack_v;
      #1;
      chk("o_rd", o_rd, 64'(i_vld && !i_clear && cyc >= ready_at));
      chk("o_busy", o_busy, 64'((last_pop < cyc && cyc < ready_at) || (|i_thr_busy)));
      chk("o_err", o_err, 64'(cyc >= err_at));
      if (i_clear) begin
        ready_at = cyc + 1;
        fl_on = 0;
        sync_on = 0;
        err_at = INF;
        if (sb.size() > 0 && sb[0].pcyc + 2 > cyc) sb.delete();
      end else begin
        if (fl_on && cyc >= fl_disp && i_thr_ack[fl_th]) begin
          fl_on = 0;
          ready_at = cyc + 1;
        end
        if (sync_on && cyc >= sync_from && i_thr_busy == '0) begin
          sync_on = 0;
          ready_at = cyc + 1;
        end
      end
      if (o_rd && cq.size() > 0) begin
        pc = cq.pop_front();
        pop_log.push_back(cyc);
        last_pop = cyc;
        if (pc.op == 5'h00) ready_at = cyc + 2;
        else if (pc.op == 5'h01) begin
          ready_at = INF;
          sync_on = 1;
          sync_from = cyc + 2;
        end else if (int'(pc.th) >= NTHR) begin
          ready_at = cyc + 2;
          if (err_at == INF) err_at = cyc + 2;
        end else begin
          ready_at = INF;
          fl_on = 1;
          fl_th = int'(pc.th);
          fl_disp = cyc + 2;
          sb.push_back('{pc, cyc});
        end
      end
    end
  end

  // monitor: every newly raised thread valid retires the oldest expected dispatch
  always @(negedge clk) begin
    #2;
    if (nrst) begin
      chk("onehot", 64'($onehot0(o_thr_vld)), 1);
      if (o_thr_vld != '0 && prev_vld == '0) begin
        if (sb.size() == 0) chk("spurious vld", o_thr_vld, 0);
        else begin
          me = sb.pop_front();
          cur = me.c;
          chk("vld", o_thr_vld, 64'(NTHR'(1) << me.c.th));
          chk("op", o_thr_op, me.c.op);
          chk("pl", o_thr_pl, me.c.pl);
          chk("latency", cyc, me.pcyc + 2);
        end
      end else if (o_thr_vld != '0) begin
        chk("hold vld", o_thr_vld, 64'(NTHR'(1) << cur.th));
        chk("hold op", o_thr_op, cur.op);
        chk("hold pl", o_thr_pl, cur.pl);
      end
    end
    prev_vld = o_thr_vld;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, n, s, t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst o_rd", o_rd, 0);
    chk("rst vld", o_thr_vld, 0);
    chk("rst op", o_thr_op, 0);
    chk("rst pl", o_thr_pl, 0);
    chk("rst err", o_err, 0);
    chk("rst busy", o_busy, 0);
    nrst = 1;
    // basic dispatch, ack three cycles after valid
    ack_mode = 2;
    cq.push_back('{5'h04, 3'd2, 48'h1234});
    wait_pops(1);
    n = pop_log[0];
    wait_until(n + 5);
    ack_force = NTHR'(4);
    tick();
    ack_force = '0;
    @(negedge clk);
    #3;
    chk("t1 vld after ack", o_thr_vld, 0);
    settle();
    // back-to-back immediate acks
    ack_mode = 1;
    base = pop_log.size();
    for (int i = 0; i < 4; i++) cq.push_back('{5'(5 + i), 3'(i), 48'(32'hA000 + i)});
    wait_pops(base + 4);
    for (int i = 1; i < 4; i++) chk("t2 spacing", pop_log[base+i] - pop_log[base+i-1], 3);
    settle();
    // barrier
    busy_knob = NTHR'(5);
    base = pop_log.size();
    cq.push_back('{5'h01, 3'd0, 48'h0});
    cq.push_back('{5'h06, 3'd3, 48'hABCD});
    wait_pops(base + 1);
    s = pop_log[base];
    wait_until(s + 10);
    chk("t3 busy", o_busy, 1);
    chk("t3 no pop", pop_log.size(), base + 1);
    busy_knob = '0;
    wait_pops(base + 2);
    chk("t3 release pop", pop_log[base+1], s + 11);
    settle();
    // bad thread
    base = pop_log.size();
    cq.push_back('{5'h07, 3'd6, 48'h5555});
    cq.push_back('{5'h09, 3'd1, 48'h7777});
    wait_pops(base + 2);
    chk("t4 spacing", pop_log[base+1] - pop_log[base], 2);
    settle();
    chk("t4 err held", o_err, 1);
    clear_req = 1;
    tick();
    tick();
    chk("t4 err cleared", o_err, 0);
    settle();
    // abort with colliding ack
    ack_mode = 2;
    base = pop_log.size();
    cq.push_back('{5'h0A, 3'd5, 48'hDEAD_BEEF});
    wait_pops(base + 1);
    n = pop_log[base];
    cq.push_back('{5'h0B, 3'd0, 48'h0BB0});
    wait_until(n + 3);
    clear_req = 1;
    ack_force = NTHR'(32);
    tick();
    ack_force = '0;
    chk("t5 vld", o_thr_vld, 0);
    chk("t5 err", o_err, 0);
    chk("t5 busy", o_busy, 0);
    chk("t5 pops", pop_log.size(), base + 1);
    ack_mode = 1;
    settle();
    // NOP turnaround, then async reset mid-dispatch
    ack_mode = 2;
    base = pop_log.size();
    cq.push_back('{5'h00, 3'd1, 48'h1111});
    cq.push_back('{5'h03, 3'd0, 48'hCAFE});
    wait_pops(base + 2);
    chk("t6 nop spacing", pop_log[base+1] - pop_log[base], 2);
    wait_until(pop_log[base+1] + 3);
    chk("t6 dispatching", o_thr_vld, 1);
    #1;
    nrst = 0;
    #1;
    chk("t6 rst vld", o_thr_vld, 0);
    chk("t6 rst op", o_thr_op, 0);
    chk("t6 rst pl", o_thr_pl, 0);
    chk("t6 rst err", o_err, 0);
    chk("t6 rst busy", o_busy, 0);
    chk("t6 rst rd", o_rd, 0);
    sb.delete();
    cq.delete();
    fl_on = 0;
    sync_on = 0;
    ready_at = 0;
    err_at = INF;
    tick();
    tick();
    nrst = 1;
    settle();
    // randomized traffic with random busy, noise acks and clears
    rnd = 1;
    ack_mode = 0;
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(7);
      cq.push_back('{(r == 0) ? 5'h00 : (r == 1) ? 5'h01 : 5'($urandom_range(31, 2)),
                     3'($urandom_range(7)), 48'({$urandom, $urandom})});
    end
    t = 0;
    while ((cq.size() > 0 || fl_on || sync_on) && t < 20000) begin
      tick();
      t++;
    end
    rnd = 0;
    ack_mode = 1;
    settle();
    chk("drain", cq.size(), 0);
    chk("sb empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
